// File: rtl/sync_dp_ram_fifo_if.sv
// Producer/consumer bundle for sync_dp_ram_fifo: valid/ready in and out, plus occupancy status.
// The FIFO uses the slave view; whatever drives the FIFO uses the master view.
interface sync_dp_ram_fifo_if #(
    parameter int NUMBER_OF_LINES = 16,
    parameter int DATA_WIDTH      = 128
);
    localparam int CW = $clog2(NUMBER_OF_LINES + 1);

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [CW-1:0]         fill_level;
    logic                  almost_full;
    logic                  empty;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, fill_level, almost_full, empty
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, fill_level, almost_full, empty
    );
endinterface

// File: rtl/sync_dp_ram_fifo.sv
// Single-clock FIFO on an inferred simple-dual-port RAM (registered read) with a 2-entry output skid.
// Defining FIFO_FLUSH_EN adds a synchronous flush input that discards all contents.
module sync_dp_ram_fifo #(
    parameter int NUMBER_OF_LINES    = 16,
    parameter int DATA_WIDTH         = 128,
    parameter int ALMOST_FULL_THRESH = NUMBER_OF_LINES - 2
) (
    input  logic clk,
    input  logic rst,
`ifdef FIFO_FLUSH_EN
    input  logic flush,
`endif
    sync_dp_ram_fifo_if.slave bus
);
    localparam int AW = $clog2(NUMBER_OF_LINES);
    localparam int CW = $clog2(NUMBER_OF_LINES + 1);
    localparam logic [CW-1:0] DEPTH = CW'(NUMBER_OF_LINES);
    localparam logic [CW-1:0] AF_TH = CW'(ALMOST_FULL_THRESH);

    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t         mem [NUMBER_OF_LINES];
    word_t         ram_rdata_q;
    word_t         skid_q [2];
    word_t         skid_d [2];
    word_t         ent [3];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] ram_cnt_q, ram_cnt_d;
    logic [CW-1:0] fill_q, fill_d;
    logic [1:0]    skid_cnt_q, skid_cnt_d;
    logic [1:0]    held;
    logic          rd_vld_q, rd_vld_d;
    logic          in_ready_q, in_ready_d;
    logic          af_q, af_d;
    logic          empty_q, empty_d;
    logic          push, pop, rd_issue;

`ifdef FIFO_FLUSH_EN
    assign push = bus.in_valid & in_ready_q & ~flush;
`else
    assign push = bus.in_valid & in_ready_q;
`endif

    // The word sitting in the RAM read register counts as the tail of the output queue,
    // so a fresh word is visible without first being copied into the skid.
    assign held = skid_cnt_q + {1'b0, rd_vld_q};
    assign pop  = (held != 2'd0) & bus.out_ready;

    always_comb begin
        ent[0] = skid_q[0];
        ent[1] = skid_q[1];
        ent[2] = ram_rdata_q;
        if (rd_vld_q && skid_cnt_q == 2'd0) ent[0] = ram_rdata_q;
        if (rd_vld_q && skid_cnt_q == 2'd1) ent[1] = ram_rdata_q;

        skid_d[0]  = pop ? ent[1] : ent[0];
        skid_d[1]  = pop ? ent[2] : ent[1];
        skid_cnt_d = held - {1'b0, pop};

        // Issue only when the result is guaranteed a free skid slot next cycle.
        rd_issue   = (ram_cnt_q != '0) && (skid_cnt_d < 2'd2);
        rd_vld_d   = rd_issue;
        rd_ptr_d   = rd_ptr_q + AW'(rd_issue);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        ram_cnt_d  = ram_cnt_q + CW'(push) - CW'(rd_issue);
        fill_d     = fill_q + CW'(push) - CW'(pop);

`ifdef FIFO_FLUSH_EN
        if (flush) begin
            skid_cnt_d = 2'd0;
            rd_vld_d   = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            ram_cnt_d  = '0;
            fill_d     = '0;
        end
`endif

        in_ready_d = fill_d < DEPTH;
        af_d       = fill_d >= AF_TH;
        empty_d    = fill_d == '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            fill_q     <= '0;
            skid_cnt_q <= 2'd0;
            rd_vld_q   <= 1'b0;
            in_ready_q <= 1'b0;
            af_q       <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            fill_q     <= fill_d;
            skid_cnt_q <= skid_cnt_d;
            rd_vld_q   <= rd_vld_d;
            in_ready_q <= in_ready_d;
            af_q       <= af_d;
            empty_q    <= empty_d;
        end
    end

    // Storage without reset: RAM array, its read register and the skid payload.
    always_ff @(posedge clk) begin
        if (push)     mem[wr_ptr_q] <= bus.in_data;
        if (rd_issue) ram_rdata_q   <= mem[rd_ptr_q];
        skid_q[0] <= skid_d[0];
        skid_q[1] <= skid_d[1];
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = held != 2'd0;
    assign bus.out_data    = ent[0];
    assign bus.fill_level  = fill_q;
    assign bus.almost_full = af_q;
    assign bus.empty       = empty_q;

    a_fill_consistent: assert property (@(posedge clk) disable iff (rst)
        fill_q == ram_cnt_q + CW'(held));
    a_held_bound: assert property (@(posedge clk) disable iff (rst) held <= 2'd2);
`ifdef FIFO_FLUSH_EN
    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready && !flush) |=> (bus.out_valid && $stable(bus.out_data)));
`else
    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_data)));
`endif
endmodule
